bsg_mem_1rw_sync_mask_init: RTL and testbench

- Single-port synchronous RAM: one read or one write per cycle.
- Generalised successor of the plain 1rw sync memory. Adds per-slice write masking, a ready/valid request interface, a hardware clear sequence after reset, a read-valid flag, always-on last-read latching and sticky out-of-range error reporting.
- Used as the storage element beneath FIFOs and scratchpads that need known contents after reset.

---
 rtl/bsg_mem_1rw_sync_mask_init.sv | 124 ++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_init.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_init.sv
// Single-port synchronous RAM with per-slice write mask, ready/valid requests,
// post-reset clear sequence, one-cycle read valid and sticky out-of-range error.
module bsg_mem_1rw_sync_mask_init #(
    parameter int                     width_p     = 32,
    parameter int                     els_p       = 64,
    parameter int                     mask_gran_p = 8,
    parameter bit                     init_en_p   = 1'b1,
    parameter logic [mask_gran_p-1:0] init_val_p  = '0,
    localparam int mask_width_lp = width_p / mask_gran_p,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] w_mask_i,
    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    output logic                     err_o
);

    if (width_p % mask_gran_p != 0) begin : g_bad_gran
        $error("width_p must be a multiple of mask_gran_p");
    end
    if (els_p < 1) begin : g_bad_els
        $error("els_p must be at least 1");
    end

    typedef enum logic [1:0] {
        INIT,
        READY_WAIT,
        READY
    } state_e;

    state_e                   state;
    logic [addr_width_lp-1:0] init_cnt;
    logic                     accept;
    logic                     in_range;
    logic                     init_last;

    logic                     we;
    logic [addr_width_lp-1:0] waddr;
    logic [width_p-1:0]       wdata;
    logic [mask_width_lp-1:0] wmask;

    logic [width_p-1:0] mem [els_p];

    // ready_o is only ever high in READY, so it doubles as the state qualifier.
    assign accept    = v_i & ready_o;
    assign in_range  = 32'(addr_i) < 32'(els_p);
    assign init_last = (init_cnt == addr_width_lp'(els_p - 1));

    // The clear sequence and accepted writes share the single write port.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        we    = 1'b0;
        waddr = addr_i;
        wdata = data_i;
        wmask = w_mask_i;
        if (state == INIT) begin
            we    = 1'b1;
            waddr = init_cnt;
            wdata = {mask_width_lp{init_val_p}};
            wmask = '1;
        end else if (accept && w_i && in_range) begin
            we = 1'b1;
        end
    end

    // NOTE: the storage array has no reset; known contents come from the clear sequence.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < mask_width_lp; k++) begin
            if (we && wmask[k]) begin
                mem[waddr][k*mask_gran_p +: mask_gran_p] <= wdata[k*mask_gran_p +: mask_gran_p];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= init_en_p ? INIT : READY_WAIT;
            ready_o  <= 1'b0;
            v_o      <= 1'b0;
            data_o   <= '0;
            err_o    <= 1'b0;
            init_cnt <= '0;
        end else begin
            v_o <= 1'b0;
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_last) begin
                        state   <= READY;
                        ready_o <= 1'b1;
                    end
                end
                READY_WAIT: begin
                    state   <= READY;
                    ready_o <= 1'b1;
                end
                READY: begin
                    if (accept) begin
                        if (!in_range) begin
                            err_o <= 1'b1;
                        end
                        if (!w_i) begin
                            v_o    <= 1'b1;
                            data_o <= in_range ? mem[addr_i] : '0;
                        end
                    end
                end
                default: begin
                    state   <= READY;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_init.sv
// Scoreboarded random/directed bench: a word-array reference model predicts reads,
// a negedge monitor pops expectations whenever the DUT raises v_o.
module tb_bsg_mem_1rw_sync_mask_init;

    localparam int ELS = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: els_p=6 (has out-of-range addresses), clear value A5.
    logic        rst_n;
    logic        v, w, ready, v_o, err;
    logic [2:0]  addr;
    logic [31:0] data, data_o;
    logic [3:0]  mask;

    // Second DUT: clear sequence disabled.
    logic        c_rst_n;
    logic        c_v, c_w, c_ready, c_v_o, c_err;
    logic [2:0]  c_addr;
    logic [31:0] c_data, c_data_o;
    logic [3:0]  c_mask;

    bsg_mem_1rw_sync_mask_init #(
        .width_p(32), .els_p(ELS), .mask_gran_p(8), .init_en_p(1'b1), .init_val_p(8'hA5)
    ) u_dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .ready_o(ready), .w_i(w), .addr_i(addr),
        .data_i(data), .w_mask_i(mask), .data_o(data_o), .v_o(v_o), .err_o(err)
    );

    bsg_mem_1rw_sync_mask_init #(
        .width_p(32), .els_p(8), .mask_gran_p(8), .init_en_p(1'b0), .init_val_p(8'h3C)
    ) u_dut_noinit (
        .clk_i(clk), .reset_n_i(c_rst_n), .v_i(c_v), .ready_o(c_ready), .w_i(c_w), .addr_i(c_addr),
        .data_i(c_data), .w_mask_i(c_mask), .data_o(c_data_o), .v_o(c_v_o), .err_o(c_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [ELS];
    logic [31:0] exp_q [$];
    logic [31:0] exp_hold = '0;
    logic        exp_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one read result due per queued entry, otherwise v_o low and data_o held.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_q.size() > 0) begin
                    check("v_o_read", 32'(v_o), 32'd1);
                    e        = exp_q.pop_front();
                    exp_hold = e;
                    check("data_o_read", data_o, e);
                end else begin
                    check("v_o_idle", 32'(v_o), 32'd0);
                    check("data_o_hold", data_o, exp_hold);
                end
                check("err_o", 32'(err), 32'(exp_err));
            end
        end
    end

    // One request cycle; the model is updated at the edge that accepts it.
    task automatic op(input bit vv, input bit ww, input logic [2:0] a,
                      input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        v = vv; w = ww; addr = a; data = d; mask = m;
        check("ready_o", 32'(ready), 32'd1);
        @(posedge clk);
        if (vv) begin
            if (int'(a) >= ELS) begin
                exp_err = 1'b1;
                if (!ww) exp_q.push_back(32'h0);
            end else if (ww) begin
                for (int k = 0; k < 4; k++)
                    if (m[k]) model_mem[a][k*8 +: 8] = d[k*8 +: 8];
            end else begin
                exp_q.push_back(model_mem[a]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    // Release reset with a write request held high; it must be ignored until ready.
    // A non-zero abort_at re-asserts reset part way through and starts over.
    task automatic do_init(input int abort_at);
        @(negedge clk);
        rst_n = 1'b1;
        v = 1'b1; w = 1'b1; addr = 3'd0; data = 32'h1234_5678; mask = 4'hF;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            check("ready_o_before_abort", 32'(ready), 32'd0);
            rst_n = 1'b0;
            #1;
            check("ready_o_abort_reset", 32'(ready), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        for (int i = 1; i <= ELS; i++) begin
            @(negedge clk);
            check($sformatf("ready_o_init_edge%0d", i), 32'(ready), 32'(i == ELS));
        end
        v = 1'b0;
        for (int i = 0; i < ELS; i++) model_mem[i] = 32'hA5A5_A5A5;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        rst_n = 1'b0; c_rst_n = 1'b0;
        v = 1'b0; w = 1'b0; addr = '0; data = '0; mask = '0;
        c_v = 1'b0; c_w = 1'b0; c_addr = '0; c_data = '0; c_mask = '0;

        // Requests during reset on the no-init DUT must be ignored.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c_v = 1'b1; c_w = i[0]; c_addr = 3'(i); c_data = $urandom; c_mask = 4'hF;
            check("noinit_v_o_in_reset", 32'(c_v_o), 32'd0);
            check("noinit_err_in_reset", 32'(c_err), 32'd0);
            check("noinit_ready_in_reset", 32'(c_ready), 32'd0);
        end
        check("reset_ready_o", 32'(ready), 32'd0);
        check("reset_v_o", 32'(v_o), 32'd0);
        check("reset_data_o", data_o, 32'd0);
        check("reset_err_o", 32'(err), 32'd0);

        @(negedge clk);
        c_rst_n = 1'b1; c_v = 1'b0;
        @(negedge clk);
        check("noinit_ready_first_edge", 32'(c_ready), 32'd1);
        check("noinit_v_o_after_release", 32'(c_v_o), 32'd0);
        rd = $urandom;
        c_v = 1'b1; c_w = 1'b1; c_addr = 3'd3; c_data = rd; c_mask = 4'hF;
        @(negedge clk);
        c_w = 1'b0;
        @(negedge clk);
        c_v = 1'b0;
        check("noinit_read_v_o", 32'(c_v_o), 32'd1);
        check("noinit_read_data", c_data_o, rd);
        @(negedge clk);
        check("noinit_v_o_one_cycle", 32'(c_v_o), 32'd0);
        check("noinit_data_held", c_data_o, rd);
        check("noinit_err", 32'(c_err), 32'd0);

        // Main DUT: interrupted clear, then a full clear.
        do_init(3);
        for (int a = 0; a < ELS; a++) op(1'b1, 1'b0, 3'(a), 32'h0, 4'h0);
        idle(1);

        // Masked merge, then hold for five idle cycles.
        op(1'b1, 1'b1, 3'd2, 32'h1122_3344, 4'b1111);
        op(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'b0101);
        op(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        idle(5);
        check("merged_word_model", model_mem[2], 32'h11FF_33FF);

        // Write-then-read ordering and an all-zero mask.
        op(1'b1, 1'b1, 3'd5, 32'hDEAD_BEEF, 4'hF);
        op(1'b1, 1'b0, 3'd5, 32'h0, 4'h0);
        op(1'b1, 1'b1, 3'd5, 32'h0BAD_F00D, 4'h0);
        op(1'b1, 1'b0, 3'd5, 32'h0, 4'h0);

        // Out-of-range read, then out-of-range write, then sweep of valid words.
        op(1'b1, 1'b0, 3'd7, 32'h0, 4'h0);
        op(1'b1, 1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF);
        for (int a = 0; a < ELS; a++) op(1'b1, 1'b0, 3'(a), 32'h0, 4'h0);

        // Randomized traffic, mostly in range.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] a;
            a = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, ELS - 1));
            op($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(1);

        // Reset while a read result is on the outputs.
        op(1'b1, 1'b0, 3'd1, 32'h0, 4'h0);
        #1;
        check("v_o_before_reset", 32'(v_o), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_hold = '0;
        exp_err  = 1'b0;
        #1;
        check("v_o_async_reset", 32'(v_o), 32'd0);
        check("data_o_async_reset", data_o, 32'd0);
        check("err_o_async_reset", 32'(err), 32'd0);
        v = 1'b0;

        do_init(0);
        for (int a = 0; a < ELS; a++) op(1'b1, 1'b0, 3'(a), 32'h0, 4'h0);
        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
